// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch
//
// Instruction fetch unit for the bit-serial core. It pulls instruction words
// from an instruction memory with a req/ack handshake (data returned in the
// ack cycle), holds the current instruction for the decode stage and keeps
// one word of prefetch so that a steady stream of retirements can run at one
// instruction per cycle.
//
// Parameters
//   ADDR_W     program counter / instruction memory address width
//   OPERAND_W  operand width; instruction word is OPERAND_W+2 bits
//              ([OPERAND_W+1:OPERAND_W] opcode, [OPERAND_W-1:0] operand)
//
// Ports
//   i_clk        sole clock, rising edge
//   i_rst_n      synchronous active-low reset
//   o_imem_req   instruction memory read request
//   o_imem_addr  read address, valid while o_imem_req=1
//   i_imem_ack   memory accepts the request and returns data this cycle
//   i_imem_data  instruction word returned with i_imem_ack
//   i_pcincr     decode retires the instruction currently presented
//   o_instr      opcode presented to decode (NOP when not valid)
//   o_operand    operand presented to the datapath (0 when not valid)
//   o_start      o_instr/o_operand hold a valid instruction
//   o_pc         address of the instruction in o_instr
// -----------------------------------------------------------------------------
module fetch #(
    parameter int ADDR_W    = 8,
    parameter int OPERAND_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    output logic                   o_imem_req,
    output logic [ADDR_W-1:0]      o_imem_addr,
    input  logic                   i_imem_ack,
    input  logic [OPERAND_W+1:0]   i_imem_data,
    input  logic                   i_pcincr,
    output logic [1:0]             o_instr,
    output logic [OPERAND_W-1:0]   o_operand,
    output logic                   o_start,
    output logic [ADDR_W-1:0]      o_pc
);

    localparam int INSTR_W = OPERAND_W + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ADDR_W-1:0]    pc;
    logic [ADDR_W-1:0]    pc_next;
    logic [ADDR_W-1:0]    pc_plus1;
    logic [INSTR_W-1:0]   ir;
    logic [INSTR_W-1:0]   ir_next;
    logic [INSTR_W-1:0]   pbuf;
    logic [INSTR_W-1:0]   pbuf_next;
    logic                 pbuf_full;
    logic                 pbuf_full_next;
    logic                 req_int;
    logic [ADDR_W-1:0]    addr_int;
    logic                 handshake;
    logic                 exec_valid;

    // Natural wrap of the address space: the all-ones PC rolls over to 0.
    assign pc_plus1 = pc + ADDR_W'(1);

    // Memory request generation. In FETCH we ask for the word at PC. In EXEC
    // the current instruction already sits in IR, so the request looks one
    // word ahead (PC+1) as long as the prefetch buffer has room for it.
    always_comb begin
        req_int  = 1'b0;
        addr_int = pc;
        case (state)
            FETCH: begin
                req_int  = 1'b1;
                addr_int = pc;
            end
            EXEC: begin
                req_int  = ~pbuf_full;
                addr_int = pc_plus1;
            end
            default: begin
                req_int  = 1'b0;
                addr_int = pc;
            end
        endcase
    end

    // A transfer only happens when we are actually requesting; a stray ack
    // (including one seen while reset is held) is ignored.
    assign handshake = i_rst_n & req_int & i_imem_ack;

    // Next-state and datapath-update logic.
    // Retiring in EXEC has three outcomes: take the buffered word, take the
    // word arriving this very cycle (bypassing the buffer, which keeps full
    // throughput with ack tied high), or fall back to FETCH. In the fallback
    // the outstanding request address (old PC+1) already equals the new PC,
    // so the request simply stays up with an unchanged address.
    always_comb begin
        state_next     = state;
        pc_next        = pc;
        ir_next        = ir;
        pbuf_next      = pbuf;
        pbuf_full_next = pbuf_full;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (handshake) begin
                    ir_next    = i_imem_data;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (i_pcincr) begin
                    pc_next = pc_plus1;
                    if (pbuf_full) begin
                        ir_next        = pbuf;
                        pbuf_full_next = 1'b0;
                    end else if (handshake) begin
                        ir_next = i_imem_data;
                    end else begin
                        state_next = FETCH;
                    end
                end else if (handshake) begin
                    pbuf_next      = i_imem_data;
                    pbuf_full_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register. Reset returns to IDLE with PC, IR and the prefetch
    // buffer cleared so the first fetch after release is from address 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            pc        <= '0;
            ir        <= '0;
            pbuf      <= '0;
            pbuf_full <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            ir        <= ir_next;
            pbuf      <= pbuf_next;
            pbuf_full <= pbuf_full_next;
        end
    end

    // Outputs are forced quiet whenever reset is low, even in the cycle
    // reset first arrives, so an in-flight request is dropped immediately.
    assign exec_valid  = i_rst_n & (state == EXEC);
    assign o_imem_req  = i_rst_n & req_int;
    assign o_imem_addr = i_rst_n ? addr_int : '0;
    assign o_start     = exec_valid;
    assign o_instr     = exec_valid ? ir[INSTR_W-1:OPERAND_W] : 2'b00;
    assign o_operand   = exec_valid ? ir[OPERAND_W-1:0] : '0;
    assign o_pc        = i_rst_n ? pc : '0;

endmodule

// File: tb/tb_fetch.sv
// -----------------------------------------------------------------------------
// tb_fetch
//
// Self-checking bench for fetch. A behavioural model tracks the instructions
// fetched but not yet retired as a queue of addresses: its head is what decode
// must see, its length says whether a request must be outstanding. Directed
// sequences pin reset, single fetch, streaming, wrap, stall and reset during a
// request with literal values; a randomized phase then checks every cycle.
// -----------------------------------------------------------------------------
module tb_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [9:0] imem_data;
    logic       pcincr;
    logic [1:0] instr;
    logic [7:0] operand;
    logic       start;
    logic [7:0] pc;

    logic [9:0] mem [256];

    int vectors     = 0;
    int miscompares = 0;

    int         m_queue[$];
    logic [7:0] m_next_addr;
    bit         m_idle;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // The memory returns the word at whatever address is being requested.
    assign imem_data = mem[imem_addr];

    fetch #(.ADDR_W(8), .OPERAND_W(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .o_imem_req  (imem_req),
        .o_imem_addr (imem_addr),
        .i_imem_ack  (imem_ack),
        .i_imem_data (imem_data),
        .i_pcincr    (pcincr),
        .o_instr     (instr),
        .o_operand   (operand),
        .o_start     (start),
        .o_pc        (pc)
    );

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic a, input logic inc);
        rst_n    = r;
        imem_ack = a;
        pcincr   = inc;
    endtask

    // Advance the model across one rising edge with the inputs just applied.
    task automatic modelStep(input logic r, input logic a, input logic inc);
        bit req;
        if (!r) begin
            m_queue.delete();
            m_next_addr = 8'd0;
            m_idle      = 1'b1;
            return;
        end
        if (m_idle) begin
            m_idle = 1'b0;
            return;
        end
        req = (m_queue.size() < 2);
        if (inc && m_queue.size() > 0)
            void'(m_queue.pop_front());
        if (req && a) begin
            m_queue.push_back(int'(m_next_addr));
            m_next_addr = m_next_addr + 8'd1;
        end
    endtask

    // Compare every DUT output against what the model says must be visible.
    task automatic checkOutput();
        bit exp_req;
        bit exp_start;
        if (!rst_n) begin
            compare("rst_req",     32'(imem_req), 32'd0);
            compare("rst_start",   32'(start),    32'd0);
            compare("rst_instr",   32'(instr),    32'd0);
            compare("rst_operand", 32'(operand),  32'd0);
            compare("rst_pc",      32'(pc),       32'd0);
            return;
        end
        exp_req   = !m_idle && (m_queue.size() < 2);
        exp_start = (m_queue.size() > 0);
        compare("req", 32'(imem_req), 32'(exp_req));
        if (exp_req)
            compare("addr", 32'(imem_addr), 32'(m_next_addr));
        compare("start", 32'(start), 32'(exp_start));
        if (exp_start) begin
            compare("instr",   32'(instr),   32'(mem[m_queue[0]][9:8]));
            compare("operand", 32'(operand), 32'(mem[m_queue[0]][7:0]));
            compare("pc",      32'(pc),      32'(m_queue[0]));
        end else begin
            compare("instr_nop",    32'(instr),   32'd0);
            compare("operand_zero", 32'(operand), 32'd0);
        end
    endtask

    // One clock: drive inputs, step the model, then check on the falling edge.
    task automatic cycle(input logic r, input logic a, input logic inc);
        applyStimulus(r, a, inc);
        modelStep(r, a, inc);
        @(negedge clk);
        checkOutput();
    endtask

    // Directed sequences followed by a randomized run.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 10'($urandom);
        mem[0]      = 10'b11_10100101;
        m_next_addr = 8'd0;
        m_idle      = 1'b1;

        // Reset held three cycles with ack high.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            compare("reset_req",   32'(imem_req), 32'd0);
            compare("reset_start", 32'(start),    32'd0);
            compare("reset_pc",    32'(pc),       32'd0);
            compare("reset_instr", 32'(instr),    32'd0);
        end

        // Single fetch with delayed ack and no retirement.
        cycle(1'b1, 1'b0, 1'b0);
        compare("sf_req0",  32'(imem_req),  32'd1);
        compare("sf_addr0", 32'(imem_addr), 32'd0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        compare("sf_hold_addr", 32'(imem_addr), 32'd0);
        cycle(1'b1, 1'b1, 1'b0);
        compare("sf_start",   32'(start),     32'd1);
        compare("sf_instr",   32'(instr),     32'h3);
        compare("sf_operand", 32'(operand),   32'hA5);
        compare("sf_pc",      32'(pc),        32'd0);
        compare("sf_pf_req",  32'(imem_req),  32'd1);
        compare("sf_pf_addr", 32'(imem_addr), 32'd1);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            compare("sf_full_req", 32'(imem_req), 32'd0);
            compare("sf_keep_op",  32'(operand),  32'hA5);
            compare("sf_keep_pc",  32'(pc),       32'd0);
        end

        // Streaming over an all-NOP memory at one instruction per cycle.
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) mem[i] = 10'd0;
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        compare("stream_pc0", 32'(pc), 32'd0);
        for (int k = 1; k < 256; k++) begin
            cycle(1'b1, 1'b1, 1'b1);
            compare("stream_pc",    32'(pc),    32'(k));
            compare("stream_start", 32'(start), 32'd1);
        end

        // Wrap from 255 with the buffer full.
        cycle(1'b1, 1'b1, 1'b0);
        compare("wrap_full_req", 32'(imem_req), 32'd0);
        cycle(1'b1, 1'b0, 1'b1);
        compare("wrap_pc",   32'(pc),        32'd0);
        compare("wrap_req",  32'(imem_req),  32'd1);
        compare("wrap_addr", 32'(imem_addr), 32'd1);

        // Stall: retire with an empty buffer, ack withheld five cycles.
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            compare("stall_start", 32'(start),     32'd0);
            compare("stall_req",   32'(imem_req),  32'd1);
            compare("stall_addr",  32'(imem_addr), 32'd1);
            if (i < 4) cycle(1'b1, 1'b0, 1'b0);
        end
        cycle(1'b1, 1'b1, 1'b0);
        compare("stall_exec_start", 32'(start), 32'd1);
        compare("stall_exec_pc",    32'(pc),    32'd1);

        // Reset while requesting address 7, ack arriving during reset.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1);
        compare("rmr_pc",   32'(pc),        32'd6);
        compare("rmr_req",  32'(imem_req),  32'd1);
        compare("rmr_addr", 32'(imem_addr), 32'd7);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, 1'b1);
            compare("rmr_rst_req", 32'(imem_req), 32'd0);
            compare("rmr_rst_pc",  32'(pc),       32'd0);
        end
        for (int i = 0; i < 256; i++) mem[i] = 10'($urandom);
        cycle(1'b1, 1'b1, 1'b0);
        compare("rmr_first_addr", 32'(imem_addr), 32'd0);
        compare("rmr_first_req",  32'(imem_req),  32'd1);
        cycle(1'b1, 1'b1, 1'b0);
        compare("rmr_exec_pc",    32'(pc),        32'd0);
        compare("rmr_exec_start", 32'(start),     32'd1);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            cycle(logic'($urandom_range(0, 199) != 0),
                  logic'($urandom_range(0, 2) != 0),
                  logic'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter: ADDR_W, 8, program counter and instruction memory address width.
REQ-002 Parameter: OPERAND_W, 8, operand field width; instruction word width is OPERAND_W+2.
REQ-003 Port: i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: i_rst_n  input  1  reset; synchronous, active-low.
REQ-005 Port: o_imem_req  output  1  instruction memory read request.
REQ-006 Port: o_imem_addr  output  ADDR_W  read address; valid while o_imem_req=1.
REQ-007 Port: i_imem_ack  input  1  memory accepts request and returns data in the same cycle.
REQ-008 Port: i_imem_data  input  OPERAND_W+2  instruction word; [OPERAND_W+1:OPERAND_W]=opcode, [OPERAND_W-1:0]=operand.
REQ-009 Port: i_pcincr  input  1  decode stage retires the current instruction.
REQ-010 Port: o_instr  output  2  opcode presented to decode.
REQ-011 Port: o_operand  output  OPERAND_W  operand presented to the bit-serial datapath.
REQ-012 Port: o_start  output  1  o_instr/o_operand hold a valid instruction.
REQ-013 Port: o_pc  output  ADDR_W  address of the instruction in o_instr.

Function
REQ-014 The module SHALL implement states IDLE, FETCH and EXEC.
REQ-015 IDLE: lasts exactly one cycle after reset release; then FETCH.
REQ-016 FETCH: o_imem_req=1, o_imem_addr=PC; req and addr held stable until a cycle with i_imem_ack=1.
REQ-017 A handshake occurs only in a cycle with o_imem_req=1 and i_imem_ack=1; i_imem_ack with o_imem_req=0 SHALL be ignored.
REQ-018 FETCH handshake: instruction register (IR) <= i_imem_data; next state EXEC.
REQ-019 EXEC: o_start=1, o_instr=IR opcode, o_operand=IR operand, o_pc=PC.
REQ-020 Outside EXEC: o_start=0, o_instr=2'b00 (NOP), o_operand=0.
REQ-021 EXEC prefetch: with the one-entry prefetch buffer empty, o_imem_req=1 and o_imem_addr=PC+1 (mod 2^ADDR_W).
REQ-022 A prefetch handshake without i_pcincr SHALL load the buffer and mark it full; no request SHALL be issued while it is full.
REQ-023 i_pcincr in EXEC: PC <= PC+1 (mod 2^ADDR_W; 2^ADDR_W-1 wraps to 0).
REQ-024 i_pcincr with buffer full: IR <= buffer, buffer empty, remain EXEC.
REQ-025 i_pcincr with a prefetch handshake in the same cycle: IR <= i_imem_data directly, buffer stays empty, remain EXEC.
REQ-026 i_pcincr with buffer empty and no handshake: next state FETCH; request stays asserted with unchanged address (old PC+1 = new PC).
REQ-027 i_pcincr outside EXEC SHALL be ignored.
REQ-028 Throughput: with i_imem_ack tied to 1 and i_pcincr asserted every EXEC cycle, one instruction SHALL retire per cycle.
REQ-029 Instructions reach decode in address order; none skipped or duplicated.

Reset
REQ-030 While i_rst_n=0 at a clock edge: state IDLE, PC=0, IR=0, buffer empty.
REQ-031 While i_rst_n=0: o_imem_req=0, o_start=0, o_instr=2'b00, o_operand=0, o_pc=0.
REQ-032 Reset mid-handshake: outstanding request dropped; acks during reset ignored; after release the first fetch is from address 0.

Verification
REQ-033 Reset: i_rst_n=0 for 3 cycles, i_imem_ack=1 -> o_imem_req=0, o_start=0, o_pc=0, o_instr=00 throughout.
REQ-034 Single fetch: mem[0]=10'b11_10100101, ack delayed 2 cycles, i_pcincr=0 -> o_start=1, o_instr=11, o_operand=0xA5, o_pc=0; one prefetch to addr 1, then o_imem_req=0 while outputs stay unchanged.
REQ-035 Streaming: memory all NOP, i_imem_ack=1, i_pcincr=o_start -> o_pc increments 0,1,2,... every cycle and o_start stays 1.
REQ-036 Wrap: PC=255, buffer full, i_pcincr=1 -> o_pc=0 next cycle, next prefetch addr=1.
REQ-037 Stall: i_pcincr with buffer empty, ack withheld 5 cycles -> FETCH, o_start=0, o_imem_addr=new PC stable all 5 cycles, EXEC one cycle after ack.
REQ-038 Reset mid-request: i_rst_n=0 while o_imem_req=1 at addr 7, ack arrives during reset -> ack ignored; after release first request addr=0, o_pc=0.
